// File: rtl/admo_alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides. Shifts are done
// iteratively, at most SHIFT_STEP bits per cycle, so the pipeline stalls on long shifts.
module admo_alu_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int SHIFT_STEP = 4,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] operand_a_i,
  input  logic [DATA_WIDTH-1:0] operand_b_i,
  input  logic [3:0]            operator_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  localparam logic [SHAMT_W:0] STEP_C = (SHAMT_W + 1)'(SHIFT_STEP);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    logic r;
    case (op)
      OP_SLL, OP_SRL, OP_SRA: r = 1'b1;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

  // Single-cycle result for everything except multi-cycle shifts (k==0 shifts land here too).
  function automatic logic [DATA_WIDTH-1:0] alu_comb(
    input logic [3:0]            op,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [SHAMT_W-1:0]    k;
    logic [DATA_WIDTH-1:0] r;
    k = b[SHAMT_W-1:0];
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << k;
      OP_SRL:  r = a >> k;
      OP_SRA:  r = $signed(a) >>> k;
      OP_SLT:  r = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: r = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
      default: r = a;
    endcase
    return r;
  endfunction

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [SHAMT_W-1:0]    rem_q, rem_d;
  logic [3:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  valid_q, valid_d;

  logic                  accept_s;
  logic                  out_xfer_s;
  logic                  launch_shift_s;
  logic                  do_launch_s;
  logic [SHAMT_W:0]      step_s;
  logic [SHAMT_W-1:0]    rem_next_s;
  logic [DATA_WIDTH-1:0] shifted_s;

  assign in_ready_o  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready_i);
  assign out_valid_o = valid_q;
  assign result_o    = result_q;

  assign accept_s       = in_valid_i && in_ready_o;
  assign out_xfer_s     = valid_q && out_ready_i;
  assign launch_shift_s = is_shift_op(operator_i) && (operand_b_i[SHAMT_W-1:0] != {SHAMT_W{1'b0}});

  // One shifter iteration: move by min(rem, SHIFT_STEP); SRA keeps the latched sign in the MSB.
  always_comb begin
    if ({1'b0, rem_q} > STEP_C) begin
      step_s = STEP_C;
    end else begin
      step_s = {1'b0, rem_q};
    end
    rem_next_s = rem_q - step_s[SHAMT_W-1:0];
    case (op_q)
      OP_SLL:  shifted_s = shreg_q << step_s;
      OP_SRL:  shifted_s = shreg_q >> step_s;
      OP_SRA:  shifted_s = $signed(shreg_q) >>> step_s;
      default: shifted_s = shreg_q;
    endcase
  end

  // Next-state and datapath update; flush overrides every other transition.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    rem_d       = rem_q;
    op_d        = op_q;
    result_d    = result_q;
    valid_d     = valid_q;
    do_launch_s = 1'b0;

    if (flush_i) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      shreg_d = {DATA_WIDTH{1'b0}};
      rem_d   = {SHAMT_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            do_launch_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SHIFT: begin
          shreg_d = shifted_s;
          rem_d   = rem_next_s;
          if (rem_next_s == {SHAMT_W{1'b0}}) begin
            result_d = shifted_s;
            valid_d  = 1'b1;
            state_d  = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end
        ST_DONE: begin
          if (out_xfer_s && accept_s) begin
            do_launch_s = 1'b1;
          end else if (out_xfer_s) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      endcase

      if (do_launch_s) begin
        if (launch_shift_s) begin
          shreg_d = operand_a_i;
          rem_d   = operand_b_i[SHAMT_W-1:0];
          op_d    = operator_i;
          valid_d = 1'b0;
          state_d = ST_SHIFT;
        end else begin
          result_d = alu_comb(operator_i, operand_a_i, operand_b_i);
          valid_d  = 1'b1;
          state_d  = ST_DONE;
        end
      end else begin
        op_d = op_q;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      shreg_q  <= {DATA_WIDTH{1'b0}};
      rem_q    <= {SHAMT_W{1'b0}};
      op_q     <= 4'd0;
      result_q <= {DATA_WIDTH{1'b0}};
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: tb/tb_admo_alu_seq.sv
// Scoreboard bench for admo_alu_seq: the driver queues reference results and
// expected first-valid cycles, and a negedge monitor checks each output transfer.
module tb_admo_alu_seq;
  localparam int W    = 32;
  localparam int STEP = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          flush_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [W-1:0]  operand_a_i;
  logic [W-1:0]  operand_b_i;
  logic [3:0]    operator_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [W-1:0]  result_o;

  admo_alu_seq #(.DATA_WIDTH(W), .SHIFT_STEP(STEP)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .operator_i(operator_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .result_o(result_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [W-1:0] res;
    int           vcyc;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   rand_rdy = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int k;
    k = b % W;
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << k;
      4'd6:    return a >> k;
      4'd7:    return $signed(a) >>> k;
      4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:    return (a < b) ? 32'd1 : 32'd0;
      default: return a;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [W-1:0] b);
    int k;
    k = b % W;
    if (op >= 4'd5 && op <= 4'd7 && k > 0) return 1 + (k + STEP - 1) / STEP;
    return 1;
  endfunction

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit done = 1'b0;
    exp_t e;
    in_valid_i  = 1'b1;
    operator_i  = op;
    operand_a_i = a;
    operand_b_i = b;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk_i);
      if (in_ready_o) begin
        e.res  = ref_alu(op, a, b);
        e.vcyc = cyc + ref_lat(op, b);
        sb_q.push_back(e);
        done = 1'b1;
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: in_ready_o stayed 0, expected 1 within 200 cycles");
    end
    @(posedge clk_i);
    #1;
    in_valid_i  = 1'b0;
    operand_a_i = $urandom;
    operand_b_i = $urandom;
    operator_i  = 4'($urandom_range(0, 15));
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(posedge clk_i);
      n++;
    end
    if (sb_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
      sb_q.delete();
    end
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: compares output transfers, first-valid cycle, and stall stability.
  initial begin : monitor
    bit           fresh;
    bit           prev_stall;
    bit           prev_flush;
    int           vstart;
    logic [W-1:0] prev_res;
    exp_t         e;
    fresh = 1'b1; prev_stall = 1'b0; prev_flush = 1'b0; vstart = 0; prev_res = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        fresh      = 1'b1;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && !prev_flush) begin
          check("hold_valid", W'(out_valid_o), 32'd1);
          check("hold_result", result_o, prev_res);
          if (!out_ready_i) check("hold_in_ready", W'(in_ready_o), 32'd0);
        end
        if (out_valid_o && fresh) begin
          vstart = cyc;
          fresh  = 1'b0;
        end
        if (out_valid_o && out_ready_i) begin
          if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: got 0x%08h, expected no output", result_o);
          end else begin
            e = sb_q.pop_front();
            check("result", result_o, e.res);
            check("valid_cycle", W'(vstart), W'(e.vcyc));
          end
          fresh = 1'b1;
        end
        prev_stall = out_valid_o && !out_ready_i;
        prev_res   = result_o;
        prev_flush = flush_i;
      end
    end
  end

  initial begin : ready_gen
    forever begin
      @(posedge clk_i);
      #1;
      if (rand_rdy) out_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [3:0]   op;
    logic [W-1:0] a;
    rst_ni = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    operand_a_i = '0; operand_b_i = '0; operator_i = 4'd0;
    repeat (2) @(negedge clk_i);
    check("rst_out_valid", W'(out_valid_o), 32'd0);
    check("rst_in_ready", W'(in_ready_o), 32'd1);
    check("rst_result", result_o, 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    issue(4'd0, 32'hFFFF_FFFF, 32'h0000_0002);
    issue(4'd1, 32'h0000_0000, 32'h0000_0001);
    drain();

    issue(4'd5, 32'h0000_0001, 32'h0000_003F);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      check("shift_in_ready", W'(in_ready_o), 32'd0);
    end
    drain();
    issue(4'd6, 32'h8000_0000, 32'h0000_0001);
    issue(4'd7, 32'h8000_0000, 32'h0000_0004);
    issue(4'd7, 32'h8000_0000, 32'h0000_0000);
    issue(4'd8, 32'hFFFF_FFFF, 32'h0000_0000);
    issue(4'd9, 32'hFFFF_FFFF, 32'h0000_0000);
    issue(4'd12, 32'h1234_5678, 32'hDEAD_BEEF);
    drain();

    out_ready_i = 1'b0;
    issue(4'd4, 32'hF0F0_F0F0, 32'hFFFF_0000);
    repeat (5) @(negedge clk_i);
    @(posedge clk_i); #1;
    out_ready_i = 1'b1;
    issue(4'd0, 32'h0000_0005, 32'h0000_0007);
    drain();

    issue(4'd5, 32'h0000_0001, 32'h0000_003F);
    @(posedge clk_i);
    @(posedge clk_i); #2;
    rst_ni = 1'b0;
    #1;
    check("abort_rst_out_valid", W'(out_valid_o), 32'd0);
    check("abort_rst_result", result_o, 32'd0);
    check("abort_rst_in_ready", W'(in_ready_o), 32'd1);
    sb_q.delete();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;

    issue(4'd5, 32'h0000_0001, 32'h0000_003F);
    @(posedge clk_i); #1;
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    sb_q.delete();
    @(negedge clk_i);
    check("flush_in_ready", W'(in_ready_o), 32'd1);
    check("flush_out_valid", W'(out_valid_o), 32'd0);
    repeat (10) @(posedge clk_i);
    #1;
    flush_i     = 1'b1;
    in_valid_i  = 1'b1;
    operator_i  = 4'd0;
    operand_a_i = 32'h0000_0011;
    operand_b_i = 32'h0000_0022;
    @(posedge clk_i); #1;
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    @(negedge clk_i);
    check("flush_drop_valid", W'(out_valid_o), 32'd0);
    @(posedge clk_i); #1;
    issue(4'd0, 32'h0000_1000, 32'h0000_0234);
    drain();

    rand_rdy = 1'b1;
    for (int n = 0; n < 150; n++) begin
      op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       a = 32'h8000_0000;
        1:       a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      issue(op, a, $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
      #1;
    end
    drain();
    rand_rdy    = 1'b0;
    out_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/admo_alu_seq.md
Name: admo_alu_seq

Overview:
- Parametrised, registered successor to the core's combinational ALU.
- Adds shifts (SLL/SRL/SRA) and compares (SLT/SLTU). Shifts use an iterative shifter that moves at most SHIFT_STEP bits per cycle, keeping area small.
- Sits between decode/issue and writeback.
- Uses a valid/ready handshake on both the input and output sides, so the pipeline can stall on multi-cycle shifts.

Parameters:
- DATA_WIDTH, 32: operand and result width. Must be a power of 2 and at least 8.
- SHIFT_STEP, 4: maximum bits shifted per cycle. Must be a power of 2, from 1 to DATA_WIDTH.
- SHAMT_W, $clog2(DATA_WIDTH): shift-amount width. Derived; do not override.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous abort of any operation in flight.
- in_valid_i  in  1  operands and operator are valid.
- in_ready_o  out  1  block can accept a new operation.
- operand_a_i  in  DATA_WIDTH  first operand; value to be shifted.
- operand_b_i  in  DATA_WIDTH  second operand; shift amount taken from [SHAMT_W-1:0].
- operator_i  in  4  operation code.
- out_valid_o  out  1  result is valid.
- out_ready_i  in  1  consumer accepts the result.
- result_o  out  DATA_WIDTH  result.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - State goes to IDLE.
  - out_valid_o=0, in_ready_o=1, result_o=0.
  - Internal shift register and remaining-count are cleared.
- Operator encoding, 4 bits:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA.
  - 8 SLT (signed; result 1 or 0, zero-extended).
  - 9 SLTU (unsigned compare).
  - 10-15 pass operand_a_i through unchanged.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^DATA_WIDTH; no carry or overflow output.
  - Shift amount k = operand_b_i[SHAMT_W-1:0]; upper bits of operand_b_i are ignored.
- Handshake:
  - An input transfer occurs on a cycle where in_valid_i && in_ready_o.
  - An output transfer occurs on a cycle where out_valid_o && out_ready_i.
  - in_ready_o = (state==IDLE) || (state==DONE && out_ready_i). This allows back-to-back issue with no bubble.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE, on transfer, non-shift op or shift with k==0: compute combinationally, register result_o, go to DONE.
  - IDLE, on transfer, shift with k>0: load operand_a, k and the op into internal registers, go to SHIFT.
  - SHIFT, each cycle: shift by s=min(rem,SHIFT_STEP), then rem-=s.
    - SLL fills with 0; SRL fills with 0; SRA fills with the latched operand_a MSB.
    - When rem reaches 0 on this cycle, write the shifted value to result_o and go to DONE.
  - DONE: out_valid_o=1.
    - On output transfer with a new input transfer in the same cycle: handle the new input as in IDLE.
    - On output transfer alone: go to IDLE.
    - Without output transfer: hold result_o and out_valid_o stable.
- Latency, with input transfer at cycle N:
  - Non-shift op, or shift with k==0: out_valid_o high from cycle N+1.
  - Shift with k>0: out_valid_o high from cycle N+1+ceil(k/SHIFT_STEP).
  - Worst case for DATA_WIDTH=32, SHIFT_STEP=4, k=31: 8 SHIFT cycles, valid at N+9.
- Back-pressure: while out_valid_o && !out_ready_i, result_o must not change and no new input is accepted.
- Stability:
  - in_ready_o is 0 throughout SHIFT.
  - Inputs are sampled only at transfer, so they may change during SHIFT without effect.
- flush_i:
  - Next state is IDLE and out_valid_o goes to 0 on the following edge; the pending result is discarded.
  - An input presented in the same cycle as flush_i is dropped.
  - flush_i has priority over all other transitions.
- Reset mid-operation: asserting rst_ni low in any state returns immediately to the reset values. No result is produced for the aborted operation.
- SHIFT_STEP==DATA_WIDTH: any shift completes in exactly 1 SHIFT cycle.

Test Plan:
- W=32, STEP=4, ADD 0xFFFFFFFF+0x00000002 at N, out_ready=1 -> result 0x00000001, out_valid at N+1 only. Then SUB 0x0-0x1 -> 0xFFFFFFFF.
- SLL a=0x00000001, b=0x0000003F (k=31) -> 0x80000000 at N+9; in_ready_o=0 for cycles N+1..N+8. SRL 0x80000000 by 1 -> 0x40000000 at N+2.
- SRA a=0x80000000, k=4 -> 0xF8000000 at N+2. SRA with k=0 -> 0x80000000 at N+1.
- SLT a=0xFFFFFFFF, b=0x00000000 -> 0x00000001. SLTU with the same operands -> 0x00000000. Op 12 with a=0x12345678 -> 0x12345678.
- Back-pressure: XOR 0xF0F0F0F0^0xFFFF0000 -> 0x0F0FF0F0. Hold out_ready=0 for 5 cycles -> result and out_valid stable, in_ready=0. Then out_ready=1 with a new ADD on the same cycle -> new result next cycle, no bubble.
- Abort: start SLL k=31, assert rst_ni low at N+3 -> out_valid=0, result=0, in_ready=1 immediately. Repeat with flush_i at N+3 -> IDLE at N+4, no output transfer, and the next op completes correctly.
